// File: rtl/fd_pipe_skid_reg.sv
// rtl/fd_pipe_skid_reg.sv - fetch/decode pipeline register with one-entry skid buffer
module fd_pipe_skid_reg #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013,
    parameter int              CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_pcplus4,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_instr,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_pcplus4,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_main_instr, r_main_pc, r_main_pcplus4;
    logic [XLEN-1:0] r_skid_instr, r_skid_pc, r_skid_pcplus4;
    logic [CNT_W-1:0] r_stall_cnt, r_squash_cnt;
    logic            w_main_ld_in, w_main_ld_skid, w_main_ld_nop;
    logic            w_skid_ld, w_skid_clr;
    logic            w_stall, w_squash;

    // Handshake outputs come straight from the state flops.
    assign out_valid   = (r_state != S_EMPTY);
    assign in_ready    = (r_state != S_TWO);
    assign out_instr   = r_main_instr;
    assign out_pc      = r_main_pc;
    assign out_pcplus4 = r_main_pcplus4;
    assign stall_cnt   = r_stall_cnt;
    assign squash_cnt  = r_squash_cnt;

    assign w_stall  = out_valid & ~out_ready & ~flush;
    assign w_squash = flush & out_valid;

    always_comb begin
        w_state_nxt    = r_state;
        w_main_ld_in   = 1'b0;
        w_main_ld_skid = 1'b0;
        w_main_ld_nop  = 1'b0;
        w_skid_ld      = 1'b0;
        w_skid_clr     = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (in_valid) begin
                    w_main_ld_in = 1'b1;
                    w_state_nxt  = S_ONE;
                end
            end
            S_ONE: begin
                if (in_valid && out_ready) begin
                    w_main_ld_in = 1'b1;
                end else if (in_valid) begin
                    w_skid_ld   = 1'b1;
                    w_state_nxt = S_TWO;
                end else if (out_ready) begin
                    w_main_ld_nop = 1'b1;
                    w_state_nxt   = S_EMPTY;
                end
            end
            S_TWO: begin
                if (out_ready) begin
                    w_main_ld_skid = 1'b1;
                    w_state_nxt    = S_ONE;
                end
            end
            default: begin
                w_main_ld_nop = 1'b1;
                w_state_nxt   = S_EMPTY;
            end
        endcase
        // Flush wins over every transfer, including an input the stage was ready for.
        if (flush) begin
            w_state_nxt    = S_EMPTY;
            w_main_ld_in   = 1'b0;
            w_main_ld_skid = 1'b0;
            w_main_ld_nop  = 1'b1;
            w_skid_ld      = 1'b0;
            w_skid_clr     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= S_EMPTY;
            r_main_instr   <= NOP_INSTR;
            r_main_pc      <= '0;
            r_main_pcplus4 <= '0;
            r_skid_instr   <= '0;
            r_skid_pc      <= '0;
            r_skid_pcplus4 <= '0;
            r_stall_cnt    <= '0;
            r_squash_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_main_ld_nop) begin
                r_main_instr   <= NOP_INSTR;
                r_main_pc      <= '0;
                r_main_pcplus4 <= '0;
            end else if (w_main_ld_in) begin
                r_main_instr   <= in_instr;
                r_main_pc      <= in_pc;
                r_main_pcplus4 <= in_pcplus4;
            end else if (w_main_ld_skid) begin
                r_main_instr   <= r_skid_instr;
                r_main_pc      <= r_skid_pc;
                r_main_pcplus4 <= r_skid_pcplus4;
            end
            if (w_skid_clr) begin
                r_skid_instr   <= '0;
                r_skid_pc      <= '0;
                r_skid_pcplus4 <= '0;
            end else if (w_skid_ld) begin
                r_skid_instr   <= in_instr;
                r_skid_pc      <= in_pc;
                r_skid_pcplus4 <= in_pcplus4;
            end
            if (cnt_clr) begin
                r_stall_cnt  <= '0;
                r_squash_cnt <= '0;
            end else begin
                if (w_stall && (r_stall_cnt != CNT_MAX))
                    r_stall_cnt <= r_stall_cnt + 1'b1;
                if (w_squash && (r_squash_cnt != CNT_MAX))
                    r_squash_cnt <= r_squash_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/fd_pipe_skid_reg.md
FD_PIPE_SKID_REG -- requirements
Module: fd_pipe_skid_reg

Interface
REQ-001 Parameter XLEN, default 32, width of instruction, PC and PC+4 payload fields.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, instruction value driven whenever out_valid=0.
REQ-003 Parameter CNT_W, default 16, width of the stall and squash statistics counters.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-006 in_valid  in  1  fetch side presents a valid payload.
REQ-007 in_ready  out  1  stage can accept a payload this cycle.
REQ-008 in_instr / in_pc / in_pcplus4  in  XLEN each  fetch payload.
REQ-009 out_valid  out  1  decode-side payload valid.
REQ-010 out_ready  in  1  decode consumes the payload (replaces the stall input; stall = !out_ready).
REQ-011 out_instr / out_pc / out_pcplus4  out  XLEN each  decode payload.
REQ-012 flush  in  1  squash all held and incoming payloads.
REQ-013 cnt_clr  in  1  synchronous clear of both counters.
REQ-014 stall_cnt / squash_cnt  out  CNT_W each  statistics counters.

Function
REQ-015 Storage SHALL be two payload registers, MAIN (drives out_*) and SKID, controlled by states EMPTY, ONE (MAIN valid), TWO (MAIN and SKID valid).
REQ-016 out_valid SHALL equal (state != EMPTY); in_ready SHALL equal (state != TWO), decoded from the state flops only, with no combinational path from in_valid or out_ready.
REQ-017 Transfer in: in_valid & in_ready; transfer out: out_valid & out_ready.
REQ-018 EMPTY: transfer in -> MAIN <= input, go ONE; else stay.
REQ-019 ONE: in & out -> MAIN <= input, stay ONE; in only -> SKID <= input, go TWO; out only -> go EMPTY; neither -> hold.
REQ-020 TWO: out -> MAIN <= SKID, go ONE; else hold; no input accepted.
REQ-021 Latency SHALL be one cycle from transfer in to out_valid when the stage is EMPTY or draining; payload order SHALL be strictly FIFO; no payload SHALL be dropped or duplicated except by flush.
REQ-022 Whenever the state becomes EMPTY, MAIN SHALL be loaded with out_instr=NOP_INSTR, out_pc=0, out_pcplus4=0.
REQ-023 flush=1 SHALL override all transfers that cycle: next state EMPTY, MAIN loaded per REQ-022, SKID contents discarded, and any concurrent in_valid payload dropped, even though in_ready=1 that cycle.
REQ-024 stall_cnt SHALL increment by 1 on each cycle with out_valid=1, out_ready=0 and flush=0.
REQ-025 squash_cnt SHALL increment by 1 for each flush cycle in which state != EMPTY; it does not count a dropped in_valid payload.
REQ-026 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-027 cnt_clr=1 SHALL zero both counters on the next edge, overriding any increment that cycle; it does not affect the data path.

Reset
REQ-028 While reset=0 at a rising edge: state EMPTY, out_valid=0, in_ready=1, out_instr=NOP_INSTR, out_pc=0, out_pcplus4=0, SKID=0, stall_cnt=0, squash_cnt=0.
REQ-029 Reset SHALL take priority over flush and cnt_clr; asserting reset mid-operation in state TWO SHALL discard both payloads without counting a squash.
REQ-030 in_valid presented on the first edge after reset deasserts SHALL be accepted.

Verification
REQ-031 Reset, then in_valid with instr=0x00500093, pc=0x100, pcplus4=0x104, out_ready=1 -> next cycle out_valid=1 with those values; one cycle later (no input) out_valid=0, out_instr=0x00000013.
REQ-032 Stream 0x10, 0x20, 0x30 with out_ready=0 from the second cycle -> state TWO holding 0x10/0x20, in_ready=0, 0x30 held by fetch; raise out_ready -> outputs 0x10, 0x20, 0x30 in order on consecutive cycles, stall_cnt equals the number of stalled cycles.
REQ-033 In state TWO assert flush with in_valid=1 (instr 0x40) -> next cycle out_valid=0, out_instr=NOP_INSTR, in_ready=1, squash_cnt=1, 0x40 never appears at the output.
REQ-034 CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15; assert cnt_clr together with a stall cycle -> stall_cnt=0.
REQ-035 Drive reset=0 in state TWO concurrently with flush and cnt_clr -> all outputs at REQ-028 values and squash_cnt=0; first post-reset in_valid accepted.
REQ-036 Random in_valid/out_ready/flush for 10k cycles against a reference queue model -> no loss, duplication or reordering of unflushed payloads.
